// File: rtl/switch_led_pkg.sv
// Shared constants for the switch/LED bank: the four global LED display modes.
package switch_led_pkg;

  localparam logic [1:0] MODE_FOLLOW = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_BLINK  = 2'b10;
  localparam logic [1:0] MODE_INVERT = 2'b11;

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: 2-flop synchroniser, counter debouncer and press-pulse generator.
module sw_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic sw_stable,
  output logic press_pulse
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      cnt         <= '0;
      sw_stable   <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      s1          <= sw;
      s2          <= s1;
      press_pulse <= 1'b0;
      if (s2 == sw_stable) begin
        // Any sample agreeing with the accepted level restarts the run.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        sw_stable   <= s2;
        cnt         <= '0;
        press_pulse <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_led_bank.sv
// N-channel switch-to-LED controller: per-channel debouncers, toggle state,
// shared blink prescaler and a registered LED mode mux.
module switch_led_bank
  import switch_led_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DB_CYCLES  = 500000,
  parameter int BLINK_HALF = 12500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sw,
  input  logic [1:0]      mode,
  output logic [N_CH-1:0] led,
  output logic [N_CH-1:0] sw_stable,
  output logic [N_CH-1:0] press_pulse
);

  localparam int BW = $clog2(BLINK_HALF);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [N_CH-1:0] tgl;
  logic [BW-1:0]   blink_cnt;
  logic            blink_phase;
  logic [N_CH-1:0] led_nxt;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sw_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk        (clk),
      .rst        (rst),
      .sw         (sw[i]),
      .sw_stable  (sw_stable[i]),
      .press_pulse(press_pulse[i])
    );
  end

  // Toggle state lives independently of mode so switching modes never loses it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgl <= '0;
    end else begin
      tgl <= tgl ^ press_pulse;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    led_nxt = '0;
    case (mode)
      MODE_FOLLOW: led_nxt = sw_stable;
      MODE_TOGGLE: led_nxt = tgl;
      MODE_BLINK:  led_nxt = sw_stable & {N_CH{blink_phase}};
      MODE_INVERT: led_nxt = ~sw_stable;
      default:     led_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= '0;
    end else begin
      led <= led_nxt;
    end
  end

endmodule

// File: tb/tb_switch_led_bank.sv
// Directed bench for switch_led_bank with short debounce and blink periods.
module tb_switch_led_bank;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic [1:0] mode;
  logic [3:0] led;
  logic [3:0] sw_stable;
  logic [3:0] press_pulse;

  int n_cmp;
  int n_bad;

  switch_led_bank #(
    .N_CH      (4),
    .DB_CYCLES (4),
    .BLINK_HALF(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .mode       (mode),
    .led        (led),
    .sw_stable  (sw_stable),
    .press_pulse(press_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    sw   = 4'b0000;
    mode = 2'b00;
    tick(2);
    n_cmp++;
    if ({led, sw_stable, press_pulse} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_initial got %h exp 000", {led, sw_stable, press_pulse});
    end
    rst = 1'b0;
    sw  = 4'b1111;
    tick(10);
    n_cmp++;
    if (led !== 4'b1111 || sw_stable !== 4'b1111) begin
      n_bad++;
      $display("FAIL reset_prerun led %b stable %b exp 1111 1111", led, sw_stable);
    end
    // Start a falling debounce, then reset asynchronously part way through.
    sw = 4'b0000;
    tick(4);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({led, sw_stable, press_pulse} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_async got %h exp 000", {led, sw_stable, press_pulse});
    end
    sw = 4'b1111;
    tick(2);
    rst = 1'b0;
    tick(5);
    n_cmp++;
    if (sw_stable !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_restart_early stable %b exp 0000", sw_stable);
    end
    tick(1);
    n_cmp++;
    if (sw_stable !== 4'b1111 || press_pulse !== 4'b1111) begin
      n_bad++;
      $display("FAIL reset_restart stable %b pulse %b exp 1111 1111", sw_stable, press_pulse);
    end
  endtask

  task automatic test_follow();
    sw   = 4'b0000;
    mode = 2'b00;
    do_reset();
    tick(2);
    sw[0] = 1'b1;
    tick(5);
    n_cmp++;
    if (sw_stable[0] !== 1'b0 || press_pulse[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL follow_early stable %b pulse %b exp 0 0", sw_stable[0], press_pulse[0]);
    end
    tick(1);
    n_cmp++;
    if (sw_stable !== 4'b0001 || press_pulse !== 4'b0001 || led !== 4'b0000) begin
      n_bad++;
      $display("FAIL follow_edge stable %b pulse %b led %b exp 0001 0001 0000",
               sw_stable, press_pulse, led);
    end
    tick(1);
    n_cmp++;
    if (press_pulse !== 4'b0000 || led !== 4'b0001) begin
      n_bad++;
      $display("FAIL follow_led pulse %b led %b exp 0000 0001", press_pulse, led);
    end
    sw[0] = 1'b0;
    tick(6);
    n_cmp++;
    if (sw_stable !== 4'b0000 || press_pulse !== 4'b0000) begin
      n_bad++;
      $display("FAIL follow_release stable %b pulse %b exp 0000 0000", sw_stable, press_pulse);
    end
  endtask

  task automatic test_bounce();
    logic seen;
    sw   = 4'b0000;
    mode = 2'b00;
    do_reset();
    seen = 1'b0;
    sw[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin tick(1); seen |= sw_stable[1] | press_pulse[1]; end
    sw[1] = 1'b0;
    tick(1); seen |= sw_stable[1] | press_pulse[1];
    sw[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin tick(1); seen |= sw_stable[1] | press_pulse[1]; end
    sw[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin tick(1); seen |= sw_stable[1] | press_pulse[1] | led[1]; end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL bounce_reject activity %b exp 0", seen);
    end
  endtask

  task automatic test_toggle();
    logic [3:0] exp_led [6];
    exp_led = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
    sw   = 4'b0000;
    mode = 2'b01;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      sw[2] = (k % 2 == 0);
      tick(9);
      n_cmp++;
      if (led !== exp_led[k]) begin
        n_bad++;
        $display("FAIL toggle_step%0d led %b exp %b", k, led, exp_led[k]);
      end
    end
    mode = 2'b00;
    tick(1);
    n_cmp++;
    if (led !== 4'b0000) begin
      n_bad++;
      $display("FAIL toggle_to_follow led %b exp 0000", led);
    end
    mode = 2'b01;
    tick(1);
    n_cmp++;
    if (led !== 4'b0100) begin
      n_bad++;
      $display("FAIL toggle_kept led %b exp 0100", led);
    end
  endtask

  task automatic test_blink();
    logic prev;
    logic held;
    bit   found;
    sw   = 4'b0000;
    mode = 2'b10;
    do_reset();
    sw[3] = 1'b1;
    tick(6);
    n_cmp++;
    if (sw_stable !== 4'b1000) begin
      n_bad++;
      $display("FAIL blink_stable stable %b exp 1000", sw_stable);
    end
    found = 0;
    prev  = led[3];
    for (int k = 0; k < 20 && !found; k++) begin
      tick(1);
      if (led[3] !== prev) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL blink_first_edge got none exp edge within 20 cycles");
    end
    for (int p = 0; p < 2; p++) begin
      prev = led[3];
      held = 1'b1;
      for (int k = 0; k < 7; k++) begin
        tick(1);
        if (led[3] !== prev || led[2:0] !== 3'b000) held = 1'b0;
      end
      tick(1);
      n_cmp++;
      if (!held || led[3] !== ~prev) begin
        n_bad++;
        $display("FAIL blink_period%0d held %b led3 %b exp 1 %b", p, held, led[3], ~prev);
      end
    end
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      prev = led[3];
      tick(1);
      if (prev === 1'b0 && led[3] === 1'b1) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL blink_rise got none exp rise within 20 cycles");
    end
    sw[3] = 1'b0;
    tick(6);
    n_cmp++;
    if (sw_stable[3] !== 1'b0 || led[3] !== 1'b1) begin
      n_bad++;
      $display("FAIL blink_release stable %b led %b exp 0 1", sw_stable[3], led[3]);
    end
    tick(1);
    n_cmp++;
    if (led !== 4'b0000) begin
      n_bad++;
      $display("FAIL blink_off led %b exp 0000", led);
    end
  endtask

  task automatic test_invert_simultaneous();
    sw   = 4'b0000;
    mode = 2'b11;
    do_reset();
    tick(1);
    n_cmp++;
    if (led !== 4'b1111) begin
      n_bad++;
      $display("FAIL invert_idle led %b exp 1111", led);
    end
    sw = 4'b1010;
    tick(6);
    n_cmp++;
    if (sw_stable !== 4'b1010 || press_pulse !== 4'b1010) begin
      n_bad++;
      $display("FAIL invert_pulse stable %b pulse %b exp 1010 1010", sw_stable, press_pulse);
    end
    tick(1);
    n_cmp++;
    if (led !== 4'b0101 || press_pulse !== 4'b0000) begin
      n_bad++;
      $display("FAIL invert_led led %b pulse %b exp 0101 0000", led, press_pulse);
    end
    mode = 2'b01;
    tick(1);
    n_cmp++;
    if (led !== 4'b1010) begin
      n_bad++;
      $display("FAIL simul_toggle led %b exp 1010", led);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    sw    = 4'b0000;
    mode  = 2'b00;
    test_reset();
    test_follow();
    test_bounce();
    test_toggle();
    test_blink();
    test_invert_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
